// File: rtl/move_pacer.sv
// move_pacer: paces the snake movement controller. Conditions the raw
// direction keys and pause switch, rejects 180-degree reversals, and emits a
// one-cycle go strobe whose period shrinks as the snake grows.
//
// Handshake: go is a pure strobe with no ready/backpressure. The controller
// must be sitting in WAIT whenever go can fire, which holds as long as the
// minimum period is longer than its worst-case move sequence. dir is valid
// from the go cycle until the next go.
module move_pacer #(
  parameter int TICKS_BASE = 12500000,
  parameter int TICKS_STEP = 500000,
  parameter int TICKS_MIN  = 2500000,
  parameter int LEN_SHIFT  = 2,
  parameter int CNT_W      = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        pause_sw,
  input  logic        game_over,
  input  logic [10:0] length,
  output logic        go,
  output logic [1:0]  dir,
  output logic        running,
  output logic [15:0] move_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DEAD   = 2'd3
  } state_t;

  // Key bit order in the vectors below: [3]=up, [2]=down, [1]=left, [0]=right.
  logic [3:0]       key_s1_q, key_s2_q, key_prev_q;
  logic             pause_s1_q, pause_s2_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       dir_q, dir_d;
  logic             go_q, go_d;
  logic             running_q, running_d;
  logic [15:0]      mc_q, mc_d;

  logic [3:0]       key_ev;
  logic             has_ev;
  logic [1:0]       cand;
  logic [1:0]       ref_dir;
  logic [31:0]      red;
  logic [31:0]      period;
  logic [CNT_W-1:0] reload_val;

  // Two-flop synchronizers for keys and pause, plus the key edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      key_prev_q <= '0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
    end else begin
      key_s1_q   <= {key_up, key_down, key_left, key_right};
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      pause_s1_q <= pause_sw;
      pause_s2_q <= pause_s1_q;
    end
  end

  // Rising-edge key events and the single priority winner (up > down > left > right).
  always_comb begin
    key_ev = key_s2_q & ~key_prev_q;
    has_ev = |key_ev;
    cand   = 2'b00;
    if (key_ev[3])      cand = 2'b01;
    else if (key_ev[2]) cand = 2'b11;
    else if (key_ev[1]) cand = 2'b10;
    else                cand = 2'b00;
  end

  // Move period from snake length, clamped at the minimum; used only on reload.
  always_comb begin
    red = 32'(length >> LEN_SHIFT) * 32'(TICKS_STEP);
    if (red >= 32'(TICKS_BASE - TICKS_MIN)) period = 32'(TICKS_MIN);
    else                                    period = 32'(TICKS_BASE) - red;
    reload_val = CNT_W'(period - 32'd1);
  end

  // Next-state logic: game_over beats pause, which beats the tick and keys.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    go_d    = 1'b0;
    mc_d    = mc_q;
    ref_dir = dir_q;
    case (state_q)
      IDLE: begin
        if (game_over) begin
          state_d = DEAD;
        end else if (has_ev) begin
          // The first key sets the direction unconditionally.
          dir_d   = cand;
          pend_d  = cand;
          cnt_d   = reload_val;
          state_d = RUN;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = DEAD;
        end else if (pause_s2_q) begin
          // Counter is held, so a tick due at this edge fires after resume.
          state_d = PAUSED;
        end else begin
          if (cnt_q == '0) begin
            go_d    = 1'b1;
            dir_d   = pend_q;
            cnt_d   = reload_val;
            mc_d    = (mc_q == 16'hFFFF) ? mc_q : mc_q + 16'd1;
            // A key landing on the commit edge is judged against the new dir.
            ref_dir = pend_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (has_ev && ((cand ^ 2'b10) != ref_dir)) pend_d = cand;
        end
      end
      PAUSED: begin
        if (game_over)        state_d = DEAD;
        else if (!pause_s2_q) state_d = RUN;
      end
      default: begin
        state_d = DEAD;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // Pacer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 2'b00;
      dir_q     <= 2'b00;
      go_q      <= 1'b0;
      running_q <= 1'b0;
      mc_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      dir_q     <= dir_d;
      go_q      <= go_d;
      running_q <= running_d;
      mc_q      <= mc_d;
    end
  end

  assign go         = go_q;
  assign dir        = dir_q;
  assign running    = running_q;
  assign move_count = mc_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_move_pacer.sv
// tb_move_pacer: directed test of move_pacer with a short period
// (TICKS_BASE=20, TICKS_STEP=4, TICKS_MIN=8, LEN_SHIFT=1, CNT_W=8).
// Inputs are driven on the falling edge; outputs are sampled there too.
module tb_move_pacer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic        pause_sw = 1'b0;
  logic        game_over = 1'b0;
  logic [10:0] length = 11'd0;
  logic        go;
  logic [1:0]  dir;
  logic        running;
  logic [15:0] move_count;
  logic [1:0]  state_dbg;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          n;
  int          go_seen;
  logic [1:0]  exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_DEAD = 2'd3;

  move_pacer #(
    .TICKS_BASE(20), .TICKS_STEP(4), .TICKS_MIN(8), .LEN_SHIFT(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .pause_sw(pause_sw), .game_over(game_over), .length(length),
    .go(go), .dir(dir), .running(running), .move_count(move_count),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts falling edges until go is seen (bounded at 200).
  task automatic wait_go(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!go && cycles < 200);
  endtask

  // Holds the given keys {up,down,left,right} for 4 cycles, then releases them.
  task automatic press(input logic [3:0] keys);
    {key_up, key_down, key_left, key_right} = keys;
    step(4);
    {key_up, key_down, key_left, key_right} = 4'b0000;
  endtask

  initial begin
    // Reset values
    step(3);
    check("rst_go", go, 0);
    check("rst_dir", dir, 0);
    check("rst_running", running, 0);
    check("rst_count", move_count, 0);
    check("rst_state", state_dbg, S_IDLE);
    rst = 1'b1;
    step(2);

    // 1: first key starts RUN three edges later, period 20 at length 0
    key_up = 1'b1;
    step(3);
    key_up = 1'b0;
    check("t1_state", state_dbg, S_RUN);
    check("t1_dir", dir, 2'b01);
    check("t1_go", go, 0);
    check("t1_running", running, 1);
    wait_go(n); check("t1_gap1", n, 20);
    wait_go(n); check("t1_gap2", n, 20);
    wait_go(n); check("t1_gap3", n, 20);
    check("t1_count", move_count, 3);
    check("t1_dir_go", dir, 2'b01);

    // 2: length changes take effect on the following reload only
    length = 11'd4;
    wait_go(n); check("t2_len4_cur", n, 20);
    wait_go(n); check("t2_len4_new", n, 12);
    length = 11'd6;
    wait_go(n); check("t2_len6_cur", n, 12);
    wait_go(n); check("t2_len6_new", n, 8);
    length = 11'd100;
    wait_go(n); check("t2_len100_a", n, 8);
    wait_go(n); check("t2_len100_b", n, 8);
    check("t2_count", move_count, 9);

    // 3: reversal rejection and key priority (dir is 01 here)
    exp_q.push_back(2'b00);  // right accepted
    exp_q.push_back(2'b00);  // left is a reversal of right
    exp_q.push_back(2'b01);  // up accepted
    exp_q.push_back(2'b10);  // left accepted
    exp_q.push_back(2'b01);  // up+left: up wins
    exp_q.push_back(2'b01);  // down+left: down wins and is a reversal
    press(4'b0001); wait_go(n); check("t3_gap_r", n, 4);  check("t3_dir_r", dir, exp_q.pop_front());
    press(4'b0010); wait_go(n); check("t3_gap_l", n, 4);  check("t3_dir_rev", dir, exp_q.pop_front());
    press(4'b1000); wait_go(n); check("t3_gap_u", n, 4);  check("t3_dir_u", dir, exp_q.pop_front());
    press(4'b0010); wait_go(n); check("t3_gap_l2", n, 4); check("t3_dir_l", dir, exp_q.pop_front());
    press(4'b1010); wait_go(n); check("t3_gap_ul", n, 4); check("t3_dir_ul", dir, exp_q.pop_front());
    press(4'b0110); wait_go(n); check("t3_gap_dl", n, 4); check("t3_dir_dl", dir, exp_q.pop_front());

    // 3b: key event on the commit edge (dir=01, pending set to left earlier)
    key_left = 1'b1;
    step(4);
    key_left = 1'b0;
    step(1);
    key_down = 1'b1;
    wait_go(n);
    check("t3_cm_gap", n, 3);
    check("t3_cm_dir_old", dir, 2'b10);
    key_down = 1'b0;
    wait_go(n);
    check("t3_cm_gap2", n, 8);
    check("t3_cm_dir_new", dir, 2'b11);
    check("t3_count", move_count, 17);

    // 4: pause at counter 5, key during pause ignored, resume 6 cycles to go
    pause_sw = 1'b1;
    go_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (go) go_seen++;
      if (i == 10) key_left = 1'b1;
      if (i == 14) key_left = 1'b0;
    end
    check("t4_no_go", go_seen, 0);
    check("t4_state", state_dbg, S_PAUSED);
    check("t4_running", running, 0);
    pause_sw = 1'b0;
    wait_go(n);
    check("t4_resume_gap", n, 9);
    check("t4_dir", dir, 2'b11);
    check("t4_count", move_count, 18);

    // 5: game_over on the commit edge suppresses go and freezes everything
    step(7);
    game_over = 1'b1;
    step(1);
    check("t5_go", go, 0);
    check("t5_state", state_dbg, S_DEAD);
    check("t5_running", running, 0);
    step(1);
    game_over = 1'b0;
    go_seen = 0;
    key_up = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (go) go_seen++;
      if (i == 5) key_up = 1'b0;
    end
    check("t5_no_go", go_seen, 0);
    check("t5_dir", dir, 2'b11);
    check("t5_count", move_count, 18);
    check("t5_still_dead", state_dbg, S_DEAD);
    rst = 1'b0;
    #1;
    check("t5_rst_go", go, 0);
    check("t5_rst_dir", dir, 0);
    check("t5_rst_running", running, 0);
    check("t5_rst_count", move_count, 0);
    check("t5_rst_state", state_dbg, S_IDLE);
    step(2);
    rst = 1'b1;
    step(2);

    // 6: first key is not reversal-checked; reset while go is high
    key_left = 1'b1;
    step(3);
    key_left = 1'b0;
    check("t6_state", state_dbg, S_RUN);
    check("t6_dir", dir, 2'b10);
    wait_go(n);
    check("t6_gap", n, 8);
    check("t6_go_high", go, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_go", go, 0);
    check("t6_rst_count", move_count, 0);
    check("t6_rst_running", running, 0);
    step(2);
    rst = 1'b1;
    go_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (go) go_seen++;
    end
    check("t6_no_go", go_seen, 0);
    check("t6_idle", state_dbg, S_IDLE);

    // Report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/move_pacer.md
Name: move_pacer

Overview:
- Upstream pacing stage for the snake movement controller.
- Generates the single-cycle `go` pulse that releases one body-move/redraw sequence from the controller's WAIT state.
- Supplies the committed direction `dir`, which the head-update datapath uses on that move.
- Takes raw direction keys, rejects 180° reversals, speeds up as `length` grows, and supports pause and game-over freeze.

Parameters:
- TICKS_BASE, 12500000: move period in clocks at length 0 (4 moves/s at 50 MHz).
- TICKS_STEP, 500000: period reduction per length step.
- TICKS_MIN, 2500000: minimum period; must exceed the worst-case move sequence of the movement controller.
- LEN_SHIFT, 2: length step = length >> LEN_SHIFT.
- CNT_W, 24: tick counter width; must hold TICKS_BASE-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- key_up, key_down, key_left, key_right  in  1 each  raw direction keys, active-high, asynchronous to clk
- pause_sw  in  1  pause level, asynchronous
- game_over  in  1  collision flag, synchronous level
- length  in  11  current snake length
- go  out  1  one-cycle move strobe to the movement controller
- dir  out  2  committed direction: 00 right, 01 up, 10 left, 11 down
- running  out  1  high while in RUN
- move_count  out  16  moves issued, saturating

Behaviour:
- Reset values:
  - go=0, dir=00, running=0, move_count=0.
  - pending=00, counter=0, state IDLE.
  - Synchronizer flops all 0.
- Input conditioning:
  - Keys and pause_sw each pass through a 2-flop synchronizer; keys then go through a rising-edge detector.
  - A pin rise becomes a key event in the 3rd clk edge after the change.
- Key priority when several events occur in one cycle: up > down > left > right. Only the winner is considered.
- Reverse rule: a candidate is a reversal when (candidate ^ 2'b10) equals the reference direction.
  - The reference direction is dir, or the value being committed to dir at that same edge.
  - Reversals are discarded; a candidate equal to the reference is accepted, which is harmless.
- Period:
  - red = (length >> LEN_SHIFT) * TICKS_STEP, computed at 32 bits.
  - P = TICKS_MIN if red >= TICKS_BASE - TICKS_MIN, else TICKS_BASE - red.
  - P is sampled only when the counter is reloaded.
- States:
  - IDLE:
    - counter held, no go.
    - First key event: dir<=key and pending<=key with no reverse check; counter<=P-1; go to RUN.
    - pause_sw is ignored in IDLE.
  - RUN:
    - running=1; counter decrements each cycle.
    - Accepted key events overwrite pending.
    - At an edge where counter==0:
      - go<=1 for exactly one cycle;
      - dir<=pending;
      - counter<=P-1;
      - move_count increments, saturating at 16'hFFFF.
    - Timing: with the first RUN cycle numbered 0, go is high in cycles P, 2P, 3P, ... (P re-evaluated at each reload). dir changes in the same cycle go rises and is stable until the next go.
  - PAUSED:
    - Entered from RUN when synced pause is 1.
    - counter, pending and dir all hold; key events are dropped; go=0.
    - When synced pause returns to 0, go back to RUN and resume from the held counter value.
    - Entering PAUSED at the same edge where counter==0 suppresses that go; it fires on the first RUN cycle after resume.
  - DEAD:
    - game_over=1 in any state moves to DEAD on the next edge. This has priority over go, pause and keys.
    - go=0; dir and move_count hold; running=0.
    - Exit only by reset.
- Simultaneous key event and go commit: the commit uses the old pending. The new key is then checked against the value being committed and, if accepted, becomes pending for the next tick.
- Reset mid-operation: immediate asynchronous return to the reset values. Any go in flight is dropped.

Test Plan (TICKS_BASE=20, TICKS_STEP=4, TICKS_MIN=8, LEN_SHIFT=1, CNT_W=8):
1. Reset, length=0, raise key_up → 3 edges later state RUN, dir=01, go=0. go pulses exactly one cycle at RUN cycles 20, 40, 60; move_count=3 after the third pulse.
2. length=4 → P=12; length=6 → P=8; length=100 → P=8. Check go spacing after the next reload in each case. Change length mid-period → the current period is unaffected.
3. dir=00 (right), press key_left → discarded, next go keeps dir=00. Then press key_up → next go gives dir=01. Press up and left in the same cycle → up wins.
4. In RUN, assert pause_sw for 50 cycles at counter=5 → no go while paused, counter holds 5. go follows 6 cycles after RUN resumes. Key pressed during pause is ignored.
5. Assert game_over coincident with counter==0 → no go; running=0 and no go from then on; dir and move_count frozen. Reset → all outputs 0, state IDLE.
6. Reset asserted mid-period while go is high → go=0 immediately, move_count=0, no pulses until a new key press.
